mult_div_unit: RTL and testbench

Iterative, parametrised multiply/divide unit that owns the HI/LO register pair for the MIPS core. It replaces single-cycle combinational mult/div with a WIDTH-cycle shift-add multiplier and restoring divider. It exposes a start/busy/done handshake so the control path can stall dependent mfhi/mflo instructions. It sits beside the ALU in the execute stage and also services mthi/mtlo writes.

---
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   Multiply is a WIDTH-cycle shift-add (multiplier bits LSB first);
//   divide is a WIDTH-cycle restoring divider (quotient bits MSB first).
//   Signed operations run on magnitudes and are sign-corrected in FIX.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   start  : begin an operation (only accepted while busy=0)
//   op     : 00 mult, 01 multu, 10 div, 11 divu
//   a, b   : rs / rt operands
//   hi_we  : mthi write enable (IDLE only)
//   lo_we  : mtlo write enable (IDLE only)
//   wdata  : mthi/mtlo data
//   busy   : operation in progress
//   done   : one-cycle pulse, HI/LO hold the new result
//   hi, lo : HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 res_neg_q, res_neg_d;   // product / quotient sign
  logic                 rem_neg_q, rem_neg_d;   // remainder sign (dividend sign)
  logic                 div_zero_q, div_zero_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;           // product accumulator; low half is quotient for div
  logic [WIDTH-1:0]     rem_q, rem_d;           // divide partial remainder
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Operand magnitudes for the start cycle
  logic                 op_signed;
  logic [WIDTH-1:0]     a_mag, b_mag;

  // Datapath intermediates
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;              // W+1-bit trial partial remainder
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below the divisor, so W bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    prod_fix  = res_neg_q ? (~acc_q + 1'b1) : acc_q;
    // A divide by zero keeps the raw all-ones quotient regardless of sign.
    quot_fix  = (res_neg_q && !div_zero_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d   = op[1];
          div_zero_d = (b == '0);
          cnt_d      = '0;
          rem_d      = '0;
          if (op[1]) begin
            // Dividend shifts out of the low half MSB first, quotient shifts in.
            opnd_d    = b_mag;
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            res_neg_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_d = op_signed && a[WIDTH-1];
          end else begin
            // Multiplier sits in the low half and is consumed LSB first.
            opnd_d    = a_mag;
            acc_d     = {{WIDTH{1'b0}}, b_mag};
            res_neg_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_d = 1'b0;
          end
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          rem_d              = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         hi_we, lo_we;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests_run = 0;
  int failed    = 0;

  logic [2*W-1:0] exp_q[$];
  string          name_q[$];

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses done.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        logic [2*W-1:0] e;
        string          nm;
        if (exp_q.size() == 0) begin
          tests_run++;
          failed++;
          $display("FAIL unexpected_done actual=done expected=no_done hi=0x%08h lo=0x%08h", hi, lo);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
          check({nm, "_lo"}, 64'(lo), 64'(e[W-1:0]));
          $display("[TB] %s done hi=0x%08h lo=0x%08h", nm, hi, lo);
        end
      end
    end
  end

  // Issue one operation and measure latency / busy length.
  // inject=1 attempts mtlo/mthi and a second start mid-run.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit inject);
    int n, busy_cycles;
    logic [W-1:0] lo_before, hi_before;
    bit seen;
    exp_q.push_back({eh, el});
    name_q.push_back(nm);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = '0; b = '0;
    lo_before = lo; hi_before = hi;
    busy_cycles = busy ? 1 : 0;
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      if (inject && n == 5) begin
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2;
      end
      @(posedge clk); #1;
      n++;
      lo_we = 1'b0; hi_we = 1'b0; start = 1'b0;
      if (inject && n == 6) begin
        check({nm, "_lo_held"}, 64'(lo), 64'(lo_before));
        check({nm, "_hi_held"}, 64'(hi), 64'(hi_before));
      end
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    if (!seen) begin
      tests_run++;
      failed++;
      $display("FAIL %s_timeout actual=no_done expected=done", nm);
    end else begin
      check({nm, "_latency"}, 64'(n), 64'(W + 1));
      check({nm, "_busy_len"}, 64'(busy_cycles), 64'(W + 1));
      check({nm, "_busy_low"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;

    run_op("mult_m3x7",   2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    // back-to-back: next start issued in the done cycle
    run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_minsq",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_m7d2",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_m7dm2",   2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_by0",    2'b11, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_m5by0",   2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_100d7",  2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0);

    // mtlo in IDLE
    @(posedge clk); #1;
    lo_we = 1'b1; wdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h0000_CAFE);
    check("mtlo_hi", 64'(hi), 64'(2));
    $display("[TB] mtlo lo=0x%08h", lo);

    // multu with ignored mid-run writes and start
    run_op("multu_3x5",   2'b01, 32'd3,         32'd5,        32'd0,         32'd15,        1'b1);

    // reset abort at iteration 10
    @(posedge clk); #1;
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    $display("[TB] abort busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done), 64'(0));

    run_op("div_100dm7",  2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
